// File: rtl/xxhash_stream.sv
// xxhash_stream: streaming XXH32 / XXH64 digest engine.
// Message bytes arrive one little-endian word per beat. Full 4-word stripes are folded into
// four accumulator lanes. The last stripe may be partial; its bytes are consumed one step
// per cycle in TAIL before the final avalanche.
//
// Handshake (both ports): a beat or a hash transfers on the rising clock edge where valid and
// ready are both high. A producer holds valid and its payload steady until that edge. in_ready
// depends only on the FSM state and never on in_valid.
module xxhash_stream #(
  parameter int WORD_SIZE = 64,
  parameter int LEN_WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WORD_SIZE-1:0]           seed,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WORD_SIZE-1:0]           in_data,
  input  logic                           in_last,
  input  logic [$clog2(WORD_SIZE/8):0]   in_nbytes,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WORD_SIZE-1:0]           out_hash,
  output logic [2:0]                     dbg_state
);

  localparam int W      = WORD_SIZE;
  localparam bit IS64   = (W == 64);
  localparam int BPW    = W / 8;
  localparam int NBW    = $clog2(BPW) + 1;
  localparam int STRIPE = 4 * BPW;
  localparam int CW     = $clog2(STRIPE) + 1;
  localparam int R      = IS64 ? 31 : 13;
  localparam int SH1    = IS64 ? 33 : 15;
  localparam int SH2    = IS64 ? 29 : 13;
  localparam int SH3    = IS64 ? 32 : 16;

  localparam logic [63:0] P1_S = IS64 ? 64'h9E3779B185EBCA87 : 64'h000000009E3779B1;
  localparam logic [63:0] P2_S = IS64 ? 64'hC2B2AE3D27D4EB4F : 64'h0000000085EBCA77;
  localparam logic [63:0] P3_S = IS64 ? 64'h165667B19E3779F9 : 64'h00000000C2B2AE3D;
  localparam logic [63:0] P4_S = IS64 ? 64'h85EBCA77C2B2AE63 : 64'h0000000027D4EB2F;
  localparam logic [63:0] P5_S = IS64 ? 64'h27D4EB2F165667C5 : 64'h00000000165667B1;
  localparam logic [W-1:0] P1 = P1_S[W-1:0];
  localparam logic [W-1:0] P2 = P2_S[W-1:0];
  localparam logic [W-1:0] P3 = P3_S[W-1:0];
  localparam logic [W-1:0] P4 = P4_S[W-1:0];
  localparam logic [W-1:0] P5 = P5_S[W-1:0];

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_COMMIT, S_CONVERGE, S_TAIL, S_AVAL, S_DONE
  } state_t;

  // Rotate left; r == 0 returns x so the right shift never reaches W.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int r);
    if (r == 0) rotl = x;
    else        rotl = (x << r) | (x >> (W - r));
  endfunction

  function automatic logic [W-1:0] lane_round(input logic [W-1:0] acc, input logic [W-1:0] inp);
    lane_round = rotl(acc + inp * P2, R) * P1;
  endfunction

  state_t               r_state, w_next;
  logic [W-1:0]         r_v [4];
  logic [W-1:0]         r_seed, r_h, r_out;
  logic [LEN_WIDTH-1:0] r_len;
  logic [4*W-1:0]       r_buf;
  logic [CW-1:0]        r_bcnt, r_pos;
  logic                 r_last;

  logic                 w_fire;
  logic [NBW-1:0]       w_nb;
  logic [CW-1:0]        w_base, w_newcnt;
  logic [1:0]           w_widx;
  logic                 w_full;
  logic [W-1:0]         w_conv, w_aval, w_chunk, w_u32, w_b, w_tail_h;
  logic [CW-1:0]        w_rem, w_tail_adv;
  logic                 w_tail_done;

  // Beat bookkeeping: effective byte count (saturated on the last beat) and buffer slot.
  always_comb begin
    w_fire = in_valid && in_ready;
    if (!in_last)                      w_nb = NBW'(BPW);
    else if (in_nbytes > NBW'(BPW))    w_nb = NBW'(BPW);
    else                               w_nb = in_nbytes;
    w_base   = (r_state == S_IDLE) ? '0 : r_bcnt;
    w_newcnt = w_base + CW'(w_nb);
    w_widx   = 2'(w_base >> $clog2(BPW));
    w_full   = (w_newcnt == CW'(STRIPE));
  end

  // Lane convergence (or short-message seed path) plus message length.
  always_comb begin
    w_conv = rotl(r_v[0], 1) + rotl(r_v[1], 7) + rotl(r_v[2], 12) + rotl(r_v[3], 18);
    if (IS64) begin
      for (int i = 0; i < 4; i++) w_conv = (w_conv ^ lane_round('0, r_v[i])) * P1 + P4;
    end
    if (r_len < LEN_WIDTH'(STRIPE)) w_conv = r_seed + P5;
    w_conv = w_conv + W'(r_len);
  end

  // One tail step: widest chunk that still fits in the remaining buffered bytes.
  always_comb begin
    w_rem       = r_bcnt - r_pos;
    w_chunk     = W'(r_buf >> {r_pos, 3'b000});
    w_u32       = W'(w_chunk[31:0]);
    w_b         = W'(w_chunk[7:0]);
    w_tail_h    = r_h;
    w_tail_adv  = '0;
    w_tail_done = (w_rem == '0);
    if (IS64 && (w_rem >= CW'(8))) begin
      w_tail_h   = rotl(r_h ^ lane_round('0, w_chunk), 27) * P1 + P4;
      w_tail_adv = CW'(8);
    end else if (w_rem >= CW'(4)) begin
      if (IS64) w_tail_h = rotl(r_h ^ (w_u32 * P1), 23) * P2 + P3;
      else      w_tail_h = rotl(r_h + w_u32 * P3, 17) * P4;
      w_tail_adv = CW'(4);
    end else if (!w_tail_done) begin
      if (IS64) w_tail_h = rotl(r_h ^ (w_b * P5), 11) * P1;
      else      w_tail_h = rotl(r_h + w_b * P5, 11) * P1;
      w_tail_adv = CW'(1);
    end
  end

  // Final avalanche mix.
  always_comb begin
    w_aval = r_h;
    w_aval = w_aval ^ (w_aval >> SH1);
    w_aval = w_aval * P2;
    w_aval = w_aval ^ (w_aval >> SH2);
    w_aval = w_aval * P3;
    w_aval = w_aval ^ (w_aval >> SH3);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE, S_ABSORB: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_full)       w_next = S_COMMIT;
          else if (in_last) w_next = S_CONVERGE;
          else              w_next = S_ABSORB;
        end
      end
      S_COMMIT:   w_next = r_last ? S_CONVERGE : S_ABSORB;
      S_CONVERGE: w_next = S_TAIL;
      S_TAIL:     if (w_tail_done) w_next = S_AVAL;
      S_AVAL:     w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
  end

  // Datapath: lane seeding, stripe buffering, commit rounds, tail and digest registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_v[i] <= '0;
      r_seed <= '0;
      r_h    <= '0;
      r_out  <= '0;
      r_len  <= '0;
      r_buf  <= '0;
      r_bcnt <= '0;
      r_pos  <= '0;
      r_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ABSORB: begin
          if (w_fire) begin
            if (r_state == S_IDLE) begin
              r_seed <= seed;
              r_v[0] <= seed + P1 + P2;
              r_v[1] <= seed + P2;
              r_v[2] <= seed;
              r_v[3] <= seed - P1;
              r_len  <= LEN_WIDTH'(w_nb);
            end else begin
              r_len  <= r_len + LEN_WIDTH'(w_nb);
            end
            r_buf[32'(w_widx) * W +: W] <= in_data;
            r_bcnt <= w_newcnt;
            r_last <= in_last;
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < 4; i++) r_v[i] <= lane_round(r_v[i], r_buf[i * W +: W]);
          r_bcnt <= '0;
        end
        S_CONVERGE: begin
          r_h   <= w_conv;
          r_pos <= '0;
        end
        S_TAIL: begin
          r_h   <= w_tail_h;
          r_pos <= r_pos + w_tail_adv;
        end
        S_AVAL:  r_out <= w_aval;
        default: ;
      endcase
    end
  end

  assign out_hash  = r_out;
  assign dbg_state = r_state;

endmodule
